// File: rtl/clock_alarm_pkg.sv
// Shared types and field widths for the digital-clock alarm block.
package clock_alarm_pkg;

    localparam int unsigned HR_W    = 5;
    localparam int unsigned MIN_W   = 6;
    localparam int unsigned SEC_W   = 6;
    localparam int unsigned HR_MAX  = 23;
    localparam int unsigned MIN_MAX = 59;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RINGING = 2'd2,
        SNOOZE  = 2'd3
    } state_t;

endpackage

// File: rtl/alarm_timer.sv
// Tick-driven up-counter shared by the ringing and snooze intervals.
// done_c fires on the tick that completes `limit` counts; the count then wraps to 0.
module alarm_timer #(
    parameter int unsigned CNT_W = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic             tick,
    input  logic [CNT_W-1:0] limit,
    output logic             done_c
);

    logic [CNT_W-1:0] count;
    logic             at_limit_c;

    assign at_limit_c = (count == (limit - CNT_W'(1)));
    assign done_c     = en & tick & ~clear & at_limit_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && tick) begin
            count <= at_limit_c ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm controller: stores the alarm time, detects the match edge and sequences
// disarmed/armed/ringing/snoozing. Define ALARM_SNOOZE_EN to build the snooze path.
module alarm_ctrl
    import clock_alarm_pkg::*;
#(
    parameter int unsigned RING_SECS   = 60,
    parameter int unsigned SNOOZE_SECS = 300,
    parameter int unsigned MAX_SNOOZE  = 3,
    parameter int unsigned CNT_W       = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_1hz,
    input  logic [HR_W-1:0]  cur_hr,
    input  logic [MIN_W-1:0] cur_min,
    input  logic [SEC_W-1:0] cur_sec,
    input  logic             arm,
    input  logic             set_alarm,
    input  logic [HR_W-1:0]  set_hr,
    input  logic [MIN_W-1:0] set_min,
    input  logic             snooze_btn,
    input  logic             stop_btn,
    output logic [HR_W-1:0]  alarm_hr,
    output logic [MIN_W-1:0] alarm_min,
    output logic             ringing,
    output logic             buzzer,
    output logic             snoozing,
    output logic             set_err
);

    state_t           state;
    logic             match_c;
    logic             match_q;
    logic             trigger_c;
    logic             load_ok_c;
    logic             snooze_ok_c;
    logic             timer_clear_c;
    logic             timer_en_c;
    logic [CNT_W-1:0] timer_limit_c;
    logic             timer_done_c;

    assign match_c   = (cur_hr == alarm_hr) & (cur_min == alarm_min) & (cur_sec == '0);
    assign trigger_c = match_c & ~match_q;
    assign load_ok_c = set_alarm & (set_hr <= HR_W'(HR_MAX)) & (set_min <= MIN_W'(MIN_MAX));

`ifdef ALARM_SNOOZE_EN
    localparam int unsigned SC_W = $clog2(MAX_SNOOZE + 1);

    logic [SC_W-1:0] snooze_cnt;
    logic            snooze_cnt_clr_c;

    assign snooze_ok_c = (state == RINGING) & snooze_btn & ~stop_btn
                       & (snooze_cnt < SC_W'(MAX_SNOOZE));

    // Cleared whenever the alarm event ends (back to ARMED or IDLE).
    assign snooze_cnt_clr_c = ~arm | load_ok_c
                            | (((state == RINGING) | (state == SNOOZE)) & stop_btn)
                            | ((state == RINGING) & timer_done_c & ~snooze_ok_c);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snooze_cnt <= '0;
        end else if (snooze_cnt_clr_c) begin
            snooze_cnt <= '0;
        end else if (snooze_ok_c) begin
            snooze_cnt <= snooze_cnt + SC_W'(1);
        end
    end
`else
    logic unused_snooze_c;

    assign snooze_ok_c     = 1'b0;
    assign unused_snooze_c = snooze_btn & (MAX_SNOOZE != 0);
`endif

    // Timer restarts on every state change and idles outside RINGING/SNOOZE.
    always_comb begin
        timer_clear_c = ~arm | load_ok_c | stop_btn | snooze_ok_c
                      | (state == IDLE) | (state == ARMED);
        timer_en_c    = (state == RINGING) | (state == SNOOZE);
        timer_limit_c = (state == SNOOZE) ? CNT_W'(SNOOZE_SECS) : CNT_W'(RING_SECS);
    end

    alarm_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear_c),
        .en     (timer_en_c),
        .tick   (tick_1hz),
        .limit  (timer_limit_c),
        .done_c (timer_done_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            alarm_hr  <= '0;
            alarm_min <= '0;
            ringing   <= 1'b0;
            buzzer    <= 1'b0;
            snoozing  <= 1'b0;
            set_err   <= 1'b0;
            match_q   <= 1'b0;
        end else begin
            match_q <= match_c;
            set_err <= set_alarm & ~load_ok_c;

            // Alarm time loads even while disarmed so it can be set before arming.
            if (load_ok_c) begin
                alarm_hr  <= set_hr;
                alarm_min <= set_min;
            end

            if (!arm) begin
                state    <= IDLE;
                ringing  <= 1'b0;
                buzzer   <= 1'b0;
                snoozing <= 1'b0;
            end else if (load_ok_c) begin
                state    <= ARMED;
                ringing  <= 1'b0;
                buzzer   <= 1'b0;
                snoozing <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= ARMED;
                    end
                    ARMED: begin
                        if (trigger_c) begin
                            state   <= RINGING;
                            ringing <= 1'b1;
                            buzzer  <= 1'b1;
                        end
                    end
                    RINGING: begin
                        if (stop_btn) begin
                            state   <= ARMED;
                            ringing <= 1'b0;
                            buzzer  <= 1'b0;
                        end else if (snooze_ok_c) begin
                            state    <= SNOOZE;
                            ringing  <= 1'b0;
                            buzzer   <= 1'b0;
                            snoozing <= 1'b1;
                        end else if (timer_done_c) begin
                            state   <= ARMED;
                            ringing <= 1'b0;
                            buzzer  <= 1'b0;
                        end else if (tick_1hz) begin
                            buzzer <= ~buzzer;
                        end
                    end
`ifdef ALARM_SNOOZE_EN
                    SNOOZE: begin
                        if (stop_btn) begin
                            state    <= ARMED;
                            snoozing <= 1'b0;
                        end else if (timer_done_c) begin
                            state    <= RINGING;
                            ringing  <= 1'b1;
                            buzzer   <= 1'b1;
                            snoozing <= 1'b0;
                        end
                    end
`endif
                    default: begin
                        state    <= IDLE;
                        ringing  <= 1'b0;
                        buzzer   <= 1'b0;
                        snoozing <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed self-checking bench for alarm_ctrl; snooze steps run when ALARM_SNOOZE_EN is defined.
module tb_alarm_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick_1hz = 1'b0;
    logic [4:0] cur_hr = '0;
    logic [5:0] cur_min = '0;
    logic [5:0] cur_sec = '0;
    logic       arm = 1'b0;
    logic       set_alarm = 1'b0;
    logic [4:0] set_hr = '0;
    logic [5:0] set_min = '0;
    logic       snooze_btn = 1'b0;
    logic       stop_btn = 1'b0;
    logic [4:0] alarm_hr;
    logic [5:0] alarm_min;
    logic       ringing;
    logic       buzzer;
    logic       snoozing;
    logic       set_err;

    int n_chk  = 0;
    int n_pass = 0;

    alarm_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .tick_1hz   (tick_1hz),
        .cur_hr     (cur_hr),
        .cur_min    (cur_min),
        .cur_sec    (cur_sec),
        .arm        (arm),
        .set_alarm  (set_alarm),
        .set_hr     (set_hr),
        .set_min    (set_min),
        .snooze_btn (snooze_btn),
        .stop_btn   (stop_btn),
        .alarm_hr   (alarm_hr),
        .alarm_min  (alarm_min),
        .ringing    (ringing),
        .buzzer     (buzzer),
        .snoozing   (snoozing),
        .set_err    (set_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick_1hz = 1'b1;
            step();
            tick_1hz = 1'b0;
            step();
        end
    endtask

    task automatic pulse_set(input logic [4:0] h, input logic [5:0] m);
        set_hr    = h;
        set_min   = m;
        set_alarm = 1'b1;
        step();
        set_alarm = 1'b0;
    endtask

    task automatic pulse_stop();
        stop_btn = 1'b1;
        step();
        stop_btn = 1'b0;
    endtask

    task automatic pulse_snooze();
        snooze_btn = 1'b1;
        step();
        snooze_btn = 1'b0;
    endtask

    // Re-arm the match edge at 07:30 and let it trigger.
    task automatic ring_up();
        cur_sec = 6'd1;
        step();
        cur_sec = 6'd0;
        step();
    endtask

    function automatic logic [31:0] outs();
        return 32'({alarm_hr, alarm_min, ringing, buzzer, snoozing, set_err});
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", outs(), 32'd0);
        reset = 1'b0;
        step();
        chk("after_reset_outputs", outs(), 32'd0);

        pulse_set(5'd7, 6'd30);
        chk("load_hr", 32'(alarm_hr), 32'd7);
        chk("load_min", 32'(alarm_min), 32'd30);
        chk("load_no_err", 32'(set_err), 32'd0);

        cur_hr  = 5'd7;
        cur_min = 6'd29;
        cur_sec = 6'd59;
        arm     = 1'b1;
        step();
        step();
        chk("armed_quiet", 32'(ringing), 32'd0);

        // Seconds counter rolls 07:29:59 -> 07:30:00 on the tick edge.
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
        cur_min  = 6'd30;
        cur_sec  = 6'd0;
        chk("not_yet_ringing", 32'(ringing), 32'd0);
        step();
        chk("ring_start", 32'({ringing, buzzer}), 32'b11);

        ticks(1);
        chk("buzz_tick1", 32'(buzzer), 32'd0);
        ticks(1);
        chk("buzz_tick2", 32'(buzzer), 32'd1);
        ticks(57);
        chk("tick59_ringing", 32'({ringing, buzzer}), 32'b10);
        ticks(1);
        chk("auto_off", 32'({ringing, buzzer}), 32'b00);
        ticks(5);
        chk("no_retrigger", 32'(ringing), 32'd0);

        ring_up();
        chk("reringing", 32'(ringing), 32'd1);
`ifdef ALARM_SNOOZE_EN
        pulse_snooze();
        chk("snooze1_enter", 32'({ringing, buzzer, snoozing}), 32'b001);
        ticks(299);
        chk("snooze1_299", 32'({ringing, snoozing}), 32'b01);
        ticks(1);
        chk("snooze1_done", 32'({ringing, buzzer, snoozing}), 32'b110);
        pulse_snooze();
        ticks(300);
        chk("snooze2_done", 32'(ringing), 32'd1);
        pulse_snooze();
        ticks(300);
        chk("snooze3_done", 32'(ringing), 32'd1);
        pulse_snooze();
        chk("snooze4_ignored", 32'({ringing, snoozing}), 32'b10);
        pulse_stop();
        chk("stop_after_max", 32'({ringing, snoozing}), 32'b00);
        ring_up();
        pulse_snooze();
        chk("snooze_cnt_cleared", 32'(snoozing), 32'd1);
        arm = 1'b0;
        step();
        chk("disarm_in_snooze", 32'({ringing, buzzer, snoozing}), 32'b000);
        chk("disarm_keeps_time", 32'({alarm_hr, alarm_min}), 32'({5'd7, 6'd30}));
        arm = 1'b1;
        step();
`else
        pulse_snooze();
        chk("snooze_ignored", 32'({ringing, snoozing}), 32'b10);
        pulse_stop();
        chk("stop", 32'({ringing, buzzer}), 32'b00);
        arm = 1'b0;
        step();
        chk("disarm_keeps_time", 32'({alarm_hr, alarm_min}), 32'({5'd7, 6'd30}));
        arm = 1'b1;
        step();
`endif

        pulse_set(5'd24, 6'd10);
        chk("bad_hr_err", 32'(set_err), 32'd1);
        chk("bad_hr_hold", 32'({alarm_hr, alarm_min}), 32'({5'd7, 6'd30}));
        step();
        chk("err_one_cycle", 32'(set_err), 32'd0);
        pulse_set(5'd5, 6'd60);
        chk("bad_min_err", 32'(set_err), 32'd1);
        chk("bad_min_hold", 32'({alarm_hr, alarm_min}), 32'({5'd7, 6'd30}));

        ring_up();
        chk("ring_for_both", 32'(ringing), 32'd1);
        stop_btn   = 1'b1;
        snooze_btn = 1'b1;
        step();
        stop_btn   = 1'b0;
        snooze_btn = 1'b0;
        chk("stop_beats_snooze", 32'({ringing, snoozing}), 32'b00);

        // Load in the same cycle as the match edge discards the trigger.
        cur_sec = 6'd1;
        step();
        cur_sec = 6'd0;
        pulse_set(5'd7, 6'd30);
        step();
        chk("load_beats_trigger", 32'(ringing), 32'd0);

        ring_up();
        pulse_set(5'd7, 6'd30);
        chk("load_stops_ring", 32'({ringing, buzzer}), 32'b00);

        ring_up();
        chk("ring_before_reset", 32'(ringing), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        chk("async_reset", outs(), 32'd0);
        step();
        reset = 1'b0;
        step();
        chk("post_reset", outs(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
